serial_adder: RTL and testbench

- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds two WIDTH-bit operands plus carry-in over WIDTH/BITS_PER_CYCLE clock cycles.
- Uses a chain of BITS_PER_CYCLE full-adder cells and a registered carry.
- Sits behind a valid/ready input and output handshake so arithmetic blocks and benches can stream operands into it.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 137 +++++++++++++
 tb/tb_serial_adder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the step counter: clog2(WIDTH/BITS_PER_CYCLE), never below one bit.
    function automatic int step_cnt_width(input int width, input int bits_per_cycle);
        int steps;
        if (bits_per_cycle < 1) begin
            return 1;
        end
        steps = width / bits_per_cycle;
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit combinational full adder; chained to form the per-cycle adder slice.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds BITS_PER_CYCLE bits per clock through a chain of
// full-adder cells with a registered carry, behind valid/ready handshakes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = step_cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    // Reject parameter sets where the operand cannot be split into equal slices.
    if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
        $fatal(1, "serial_adder: BITS_PER_CYCLE must divide WIDTH exactly");
    end

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic                  carry_q, carry_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [BITS_PER_CYCLE-1:0]       cell_sum;
    logic                            last_ci;
    logic                            last_co;
    logic [WIDTH+BITS_PER_CYCLE-1:0] sum_shift;

    // Carry chain: cell 0 takes the registered carry, each later cell the previous carry-out.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = carry_q;
        end else begin : g_next
            assign ci = g_cell[i-1].co;
        end
        full_adder_cell u_cell (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .cin  (ci),
            .sum  (cell_sum[i]),
            .cout (co)
        );
    end

    assign last_ci   = g_cell[BITS_PER_CYCLE-1].ci;
    assign last_co   = g_cell[BITS_PER_CYCLE-1].co;
    // New result bits enter at the MSB end; the lowest slice falls off the bottom.
    assign sum_shift = {cell_sum, sum_q};

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> BITS_PER_CYCLE;
                b_d     = b_q >> BITS_PER_CYCLE;
                sum_d   = sum_shift[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];
                carry_d = last_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    ovf_d   = last_ci ^ last_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: result and operand registers are reset too, because sum/cout/overflow must read 0 in reset.
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder in three configurations: 8x1, 1x1 and 8x4.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    // WIDTH=8, BITS_PER_CYCLE=1
    logic       v1_in_valid, v1_in_ready, v1_cin, v1_out_valid, v1_out_ready, v1_cout, v1_ovf;
    logic [7:0] v1_a, v1_b, v1_sum;
    // WIDTH=1, BITS_PER_CYCLE=1
    logic       w1_in_valid, w1_in_ready, w1_cin, w1_out_valid, w1_out_ready, w1_cout, w1_ovf;
    logic [0:0] w1_a, w1_b, w1_sum;
    // WIDTH=8, BITS_PER_CYCLE=4
    logic       v4_in_valid, v4_in_ready, v4_cin, v4_out_valid, v4_out_ready, v4_cout, v4_ovf;
    logic [7:0] v4_a, v4_b, v4_sum;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_8x1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .a(v1_a), .b(v1_b), .cin(v1_cin), .out_valid(v1_out_valid), .out_ready(v1_out_ready),
        .sum(v1_sum), .cout(v1_cout), .overflow(v1_ovf)
    );

    serial_adder #(.WIDTH(1), .BITS_PER_CYCLE(1)) u_1x1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .a(w1_a), .b(w1_b), .cin(w1_cin), .out_valid(w1_out_valid), .out_ready(w1_out_ready),
        .sum(w1_sum), .cout(w1_cout), .overflow(w1_ovf)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_8x4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
        .a(v4_a), .b(v4_b), .cin(v4_cin), .out_valid(v4_out_valid), .out_ready(v4_out_ready),
        .sum(v4_sum), .cout(v4_cout), .overflow(v4_ovf)
    );

    // Offer one operation to the 8x1 instance (called at a negedge in IDLE) and
    // return the number of cycles from the accepting edge to out_valid.
    task automatic op_8x1(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        v1_a = a; v1_b = b; v1_cin = c; v1_in_valid = 1'b1; v1_out_ready = 1'b0;
        @(negedge clk);
        v1_in_valid = 1'b0; v1_a = 8'h00; v1_b = 8'h00; v1_cin = 1'b0;
        lat = 0;
        while (!v1_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_8x1();
        v1_out_ready = 1'b1;
        @(negedge clk);
        v1_out_ready = 1'b0;
    endtask

    task automatic op_1x1(input logic a, input logic b, input logic c, output int lat);
        w1_a = a; w1_b = b; w1_cin = c; w1_in_valid = 1'b1; w1_out_ready = 1'b0;
        @(negedge clk);
        w1_in_valid = 1'b0;
        lat = 0;
        while (!w1_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Same for the 8x4 instance, but scribbles on in_valid/a while busy.
    task automatic op_8x4(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        v4_a = a; v4_b = b; v4_cin = c; v4_in_valid = 1'b1; v4_out_ready = 1'b0;
        @(negedge clk);
        v4_in_valid = 1'b0;
        lat = 0;
        while (!v4_out_valid && lat < 40) begin
            v4_a = 8'hAA; v4_b = 8'hAA; v4_cin = 1'b1;
            v4_in_valid = ~v4_in_valid;
            @(negedge clk);
            lat++;
        end
        v4_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (v1_sum !== 8'h00) $display("FAIL reset_sum: got %h want %h", v1_sum, 8'h00); else n_pass++;
        n_checks++; if (v1_cout !== 1'b0) $display("FAIL reset_cout: got %b want 0", v1_cout); else n_pass++;
        n_checks++; if (v1_ovf !== 1'b0) $display("FAIL reset_overflow: got %b want 0", v1_ovf); else n_pass++;
        n_checks++; if (v1_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", v1_out_valid); else n_pass++;
        n_checks++; if (v1_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", v1_in_ready); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat;
        op_8x1(8'h7F, 8'h01, 1'b0, lat);
        n_checks++; if (v1_out_valid !== 1'b1) $display("FAIL async_pre_valid: got %b want 1", v1_out_valid); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (v1_out_valid !== 1'b0) $display("FAIL async_out_valid: got %b want 0", v1_out_valid); else n_pass++;
        n_checks++; if (v1_in_ready !== 1'b1) $display("FAIL async_in_ready: got %b want 1", v1_in_ready); else n_pass++;
        n_checks++; if (v1_sum !== 8'h00) $display("FAIL async_sum: got %h want %h", v1_sum, 8'h00); else n_pass++;
        n_checks++; if (v1_ovf !== 1'b0) $display("FAIL async_overflow: got %b want 0", v1_ovf); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_carry();
        int lat;
        op_8x1(8'hFF, 8'h01, 1'b0, lat);
        n_checks++; if (lat != 8) $display("FAIL carry_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (v1_sum !== 8'h00) $display("FAIL carry_sum: got %h want %h", v1_sum, 8'h00); else n_pass++;
        n_checks++; if (v1_cout !== 1'b1) $display("FAIL carry_cout: got %b want 1", v1_cout); else n_pass++;
        n_checks++; if (v1_ovf !== 1'b0) $display("FAIL carry_overflow: got %b want 0", v1_ovf); else n_pass++;
        release_8x1();
    endtask

    task automatic test_signed_overflow();
        int lat;
        op_8x1(8'h7F, 8'h01, 1'b0, lat);
        n_checks++; if (v1_sum !== 8'h80) $display("FAIL ovf_pos_sum: got %h want %h", v1_sum, 8'h80); else n_pass++;
        n_checks++; if (v1_cout !== 1'b0) $display("FAIL ovf_pos_cout: got %b want 0", v1_cout); else n_pass++;
        n_checks++; if (v1_ovf !== 1'b1) $display("FAIL ovf_pos_overflow: got %b want 1", v1_ovf); else n_pass++;
        release_8x1();
        op_8x1(8'h80, 8'hFF, 1'b0, lat);
        n_checks++; if (v1_sum !== 8'h7F) $display("FAIL ovf_neg_sum: got %h want %h", v1_sum, 8'h7F); else n_pass++;
        n_checks++; if (v1_cout !== 1'b1) $display("FAIL ovf_neg_cout: got %b want 1", v1_cout); else n_pass++;
        n_checks++; if (v1_ovf !== 1'b1) $display("FAIL ovf_neg_overflow: got %b want 1", v1_ovf); else n_pass++;
        release_8x1();
        // Results hold after leaving DONE.
        n_checks++; if (v1_sum !== 8'h7F) $display("FAIL hold_after_done_sum: got %h want %h", v1_sum, 8'h7F); else n_pass++;
    endtask

    task automatic test_truth_table();
        logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            int lat;
            v = 3'(i);
            op_1x1(v[2], v[1], v[0], lat);
            n_checks++; if (lat != 1) $display("FAIL tt_latency_%0d: got %0d want 1", i, lat); else n_pass++;
            n_checks++;
            if ({w1_cout, w1_sum} !== tt_exp[i]) $display("FAIL tt_result_%0d: got %b want %b", i, {w1_cout, w1_sum}, tt_exp[i]);
            else n_pass++;
            w1_out_ready = 1'b1;
            @(negedge clk);
            w1_out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        op_8x4(8'h3C, 8'h05, 1'b1, lat);
        n_checks++; if (lat != 2) $display("FAIL bp_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (v4_sum !== 8'h42) $display("FAIL bp_sum: got %h want %h", v4_sum, 8'h42); else n_pass++;
        n_checks++; if (v4_cout !== 1'b0) $display("FAIL bp_cout: got %b want 0", v4_cout); else n_pass++;
        n_checks++; if (v4_ovf !== 1'b0) $display("FAIL bp_overflow: got %b want 0", v4_ovf); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            v4_in_valid = ~v4_in_valid;
            v4_a = 8'hAA;
            @(negedge clk);
            n_checks++;
            if (v4_out_valid !== 1'b1 || v4_in_ready !== 1'b0 || v4_sum !== 8'h42 || v4_cout !== 1'b0)
                $display("FAIL bp_hold_%0d: got valid=%b ready=%b sum=%h cout=%b want valid=1 ready=0 sum=42 cout=0",
                         i, v4_out_valid, v4_in_ready, v4_sum, v4_cout);
            else n_pass++;
        end
        v4_in_valid = 1'b0;
        v4_out_ready = 1'b1;
        @(negedge clk);
        v4_out_ready = 1'b0;
        n_checks++; if (v4_in_ready !== 1'b1) $display("FAIL bp_back_to_idle: got %b want 1", v4_in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int  lat;
        logic seen;
        v1_a = 8'h12; v1_b = 8'h34; v1_cin = 1'b0; v1_in_valid = 1'b1; v1_out_ready = 1'b1;
        @(negedge clk);
        v1_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (v1_in_ready !== 1'b1) $display("FAIL midrun_in_ready: got %b want 1", v1_in_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (v1_out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL midrun_no_valid: got %b want 0", seen); else n_pass++;
        v1_out_ready = 1'b0;
        op_8x1(8'h12, 8'h34, 1'b0, lat);
        n_checks++; if (lat != 8) $display("FAIL midrun_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (v1_sum !== 8'h46) $display("FAIL midrun_sum: got %h want %h", v1_sum, 8'h46); else n_pass++;
        n_checks++; if (v1_cout !== 1'b0) $display("FAIL midrun_cout: got %b want 0", v1_cout); else n_pass++;
        release_8x1();
    endtask

    initial begin
        rst_n = 1'b0;
        v1_in_valid = 1'b0; v1_a = '0; v1_b = '0; v1_cin = 1'b0; v1_out_ready = 1'b0;
        w1_in_valid = 1'b0; w1_a = '0; w1_b = '0; w1_cin = 1'b0; w1_out_ready = 1'b0;
        v4_in_valid = 1'b0; v4_a = '0; v4_b = '0; v4_cin = 1'b0; v4_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_async_reset();
        test_unsigned_carry();
        test_signed_overflow();
        test_truth_table();
        test_backpressure();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
